// File: rtl/pid_channel_scheduler.sv
// pid_channel_scheduler
// Shares one PID compute core across up to four motor channels. On every
// control tick the enabled channels are serviced in ascending order: request,
// wait for the result (bounded by TIMEOUT), saturate to +/-RPM_MAX, then emit
// the result on the u_* stream. Also drives per-channel stop and sticky flags.
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   en                   global enable (0 aborts the sequence, stops all motors)
//   chn_en               per-channel enable, snapshotted at each tick
//   clr_err              pulse, clears overrun and timeout_err
//   setpoint, feedback   packed signed per-channel operands
//   pid_req/chn/sp/fb    request to PID core, held until pid_ack
//   pid_ack, pid_done    core handshake; pid_result valid with pid_done
//   u_valid_o/chn/data   one-cycle saturated result strobe
//   stop                 per-channel stop, bits >= NUM_CHN tied to 1
//   overrun              sticky, tick arrived while a sequence was busy
//   timeout_err          sticky per-channel PID timeout
//
// state | meaning
// IDLE  | waiting for control tick
// SCAN  | looking for next enabled channel in the snapshot
// REQ   | request presented to PID core, waiting for ack
// WAIT  | waiting for pid_done, bounded by TIMEOUT
// EMIT  | u_valid_o high for one cycle
module pid_channel_scheduler #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CHN    = 4,
  parameter int CLK_FREQ   = 27_000_000,
  parameter int CTRL_FREQ  = 1000,
  parameter int RPM_MAX    = 1500,
  parameter int TIMEOUT    = 255
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          en,
  input  logic [NUM_CHN-1:0]            chn_en,
  input  logic                          clr_err,
  input  logic [NUM_CHN*DATA_WIDTH-1:0] setpoint,
  input  logic [NUM_CHN*DATA_WIDTH-1:0] feedback,
  output logic                          pid_req,
  output logic [2:0]                    pid_chn,
  output logic [DATA_WIDTH-1:0]         pid_sp,
  output logic [DATA_WIDTH-1:0]         pid_fb,
  input  logic                          pid_ack,
  input  logic                          pid_done,
  input  logic signed [DATA_WIDTH-1:0]  pid_result,
  output logic                          u_valid_o,
  output logic [2:0]                    u_chn_o,
  output logic [DATA_WIDTH-1:0]         u_data_o,
  output logic [3:0]                    stop,
  output logic                          overrun,
  output logic [NUM_CHN-1:0]            timeout_err
);

  localparam int TICK_DIV = CLK_FREQ / CTRL_FREQ;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
  localparam logic signed [DATA_WIDTH-1:0] SAT_P = DATA_WIDTH'(RPM_MAX);
  localparam logic signed [DATA_WIDTH-1:0] SAT_N = DATA_WIDTH'(-RPM_MAX);

  typedef enum logic [2:0] {IDLE, SCAN, REQ, WAIT, EMIT} state_t;

  state_t                state, state_nx;
  logic [TW-1:0]         tick_cnt;
  logic                  tick;
  logic [3:0]            chn_en4;
  logic [3:0]            snap;
  logic [2:0]            idx;
  logic [WW-1:0]         wait_cnt;
  logic [3:0]            terr;
  logic [3:0]            terr_set;
  logic                  scan_end;
  logic                  cur_en;
  logic                  wait_to;
  logic [DATA_WIDTH-1:0] sp_arr [4];
  logic [DATA_WIDTH-1:0] fb_arr [4];

  // Channels are unpacked into fixed 4-entry arrays so idx[1:0] can index them
  // regardless of NUM_CHN; unused entries read as zero.
  for (genvar g = 0; g < 4; g++) begin : g_unpack
    if (g < NUM_CHN) begin : g_used
      assign sp_arr[g] = setpoint[g*DATA_WIDTH +: DATA_WIDTH];
      assign fb_arr[g] = feedback[g*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_unused
      assign sp_arr[g] = '0;
      assign fb_arr[g] = '0;
    end
  end

  function automatic logic [DATA_WIDTH-1:0] sat(input logic signed [DATA_WIDTH-1:0] v);
    if (v > SAT_P) return SAT_P;
    if (v < SAT_N) return SAT_N;
    return v;
  endfunction

  assign chn_en4     = 4'(chn_en);
  assign tick        = en && (tick_cnt == TICK_LAST);
  assign scan_end    = (idx == 3'(NUM_CHN));
  assign cur_en      = snap[idx[1:0]];
  assign wait_to     = (wait_cnt == WAIT_LAST);
  assign timeout_err = terr[NUM_CHN-1:0];

  // done wins over a coinciding timeout, so only flag when done is absent
  assign terr_set = (en && state == WAIT && !pid_done && wait_to) ? (4'b0001 << idx[1:0]) : 4'b0000;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                            tick_cnt <= '0;
    else if (!en || tick_cnt == TICK_LAST) tick_cnt <= '0;
    else                                  tick_cnt <= tick_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (!en) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: if (tick) state_nx = SCAN;
        SCAN: begin
          if (scan_end)    state_nx = IDLE;
          else if (cur_en) state_nx = REQ;
        end
        REQ:  if (pid_ack) state_nx = WAIT;
        WAIT: if (pid_done || wait_to) state_nx = EMIT;
        EMIT: state_nx = SCAN;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      snap      <= '0;
      idx       <= '0;
      wait_cnt  <= '0;
      pid_req   <= 1'b0;
      pid_chn   <= '0;
      pid_sp    <= '0;
      pid_fb    <= '0;
      u_valid_o <= 1'b0;
      u_chn_o   <= '0;
      u_data_o  <= '0;
    end else begin
      u_valid_o <= 1'b0;
      if (!en) begin
        pid_req <= 1'b0;
      end else begin
        case (state)
          IDLE: if (tick) begin
            snap <= chn_en4;
            idx  <= '0;
          end
          SCAN: if (!scan_end) begin
            if (cur_en) begin
              pid_req <= 1'b1;
              pid_chn <= idx;
              pid_sp  <= sp_arr[idx[1:0]];
              pid_fb  <= fb_arr[idx[1:0]];
            end else begin
              idx <= idx + 1'b1;
            end
          end
          REQ: if (pid_ack) begin
            pid_req  <= 1'b0;
            wait_cnt <= '0;
          end
          WAIT: begin
            wait_cnt <= wait_cnt + 1'b1;
            // u_valid_o is registered here so it is high exactly while in EMIT
            if (pid_done || wait_to) begin
              u_valid_o <= 1'b1;
              u_chn_o   <= idx;
              u_data_o  <= pid_done ? sat(pid_result) : '0;
            end
          end
          EMIT: idx <= idx + 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overrun <= 1'b0;
      terr    <= '0;
      stop    <= 4'hF;
    end else begin
      if (tick && state != IDLE) overrun <= 1'b1;
      else if (clr_err)          overrun <= 1'b0;
      terr <= (clr_err ? 4'b0000 : terr) | terr_set;
      // upper chn_en4 bits are zero for NUM_CHN < 4, tying those stops to 1
      stop <= ~({4{en}} & chn_en4 & ~terr);
    end
  end

endmodule

// File: tb/tb_pid_channel_scheduler.sv
`timescale 1ns/1ps
module tb_pid_channel_scheduler;

  logic        clk = 1'b0;
  logic        rstn, en, clr_err, pid_ack, pid_done;
  logic [3:0]  chn_en;
  logic [63:0] setpoint, feedback;
  logic [15:0] pid_result;
  logic        pid_req, u_valid_o, overrun;
  logic [2:0]  pid_chn, u_chn_o;
  logic [15:0] pid_sp, pid_fb, u_data_o;
  logic [3:0]  stop, timeout_err;

  pid_channel_scheduler #(.DATA_WIDTH(16), .NUM_CHN(4), .CLK_FREQ(1000), .CTRL_FREQ(10),
                          .RPM_MAX(1500), .TIMEOUT(255)) dut (
    .clk(clk), .rstn(rstn), .en(en), .chn_en(chn_en), .clr_err(clr_err),
    .setpoint(setpoint), .feedback(feedback),
    .pid_req(pid_req), .pid_chn(pid_chn), .pid_sp(pid_sp), .pid_fb(pid_fb),
    .pid_ack(pid_ack), .pid_done(pid_done), .pid_result(pid_result),
    .u_valid_o(u_valid_o), .u_chn_o(u_chn_o), .u_data_o(u_data_o),
    .stop(stop), .overrun(overrun), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          chn;
    logic [15:0] data;
    int          cyc;
  } ev_t;

  typedef struct {
    logic [3:0]       ce;
    logic [3:0][15:0] res;
    logic [3:0][15:0] ex;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  ev_t mon_q[$];

  // PID core model controls
  logic             ack_allow = 1'b1;
  logic [3:0]       never_done = 4'b0000;
  int               done_lat = 3;
  logic [3:0][15:0] res_tbl;
  int               cd = 0;
  logic [2:0]       cur_chn = 3'd0;
  int               ack_cnt = 0;
  logic [2:0]       last_ack_chn = 3'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
    n_chk++;
    if (act !== ex) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, ex);
    end
  endtask

  function automatic logic [15:0] sat_ref(input logic [15:0] r);
    int v;
    v = int'($signed(r));
    if (v > 1500) v = 1500;
    else if (v < -1500) v = -1500;
    return 16'(v);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // PID core: acks a request at once (when allowed), pulses done done_lat cycles later
  always @(negedge clk) begin
    if (!rstn) begin
      pid_ack = 1'b0;
      pid_done = 1'b0;
      cd = 0;
    end else begin
      pid_done = 1'b0;
      pid_result = 16'($urandom);
      if (cd > 0) begin
        cd = cd - 1;
        if (cd == 0) begin
          pid_done = 1'b1;
          pid_result = res_tbl[cur_chn[1:0]];
        end
      end
      pid_ack = pid_req && ack_allow;
      if (pid_ack) begin
        cur_chn = pid_chn;
        cd = never_done[pid_chn[1:0]] ? 0 : done_lat;
        ack_cnt++;
        last_ack_chn = pid_chn;
        chk("pid_sp", 32'(pid_sp), 32'(setpoint[int'(pid_chn)*16 +: 16]));
        chk("pid_fb", 32'(pid_fb), 32'(feedback[int'(pid_chn)*16 +: 16]));
      end
    end
  end

  always @(negedge clk) begin
    if (rstn && u_valid_o) mon_q.push_back('{int'(u_chn_o), u_data_o, cyc});
  end

  task automatic wait_ev(input int n, input int budget, input string nm);
    int k = 0;
    while (mon_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(nm, 32'(mon_q.size() >= n), 32'd1);
  endtask

  task automatic wait_ack(input int target, input int budget, input string nm);
    int k = 0;
    while (ack_cnt < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(nm, 32'(ack_cnt >= target), 32'd1);
  endtask

  task automatic start_seq();
    en = 1'b0;
    @(negedge clk);
    mon_q.delete();
    en = 1'b1;
  endtask

  task automatic run_vec(input string nm, input logic [3:0] ce,
                         input logic [3:0][15:0] res, input logic [3:0][15:0] ex);
    int k = 0;
    chn_en = ce;
    res_tbl = res;
    setpoint = {$urandom(), $urandom()};
    feedback = {$urandom(), $urandom()};
    start_seq();
    repeat (170) @(negedge clk);
    en = 1'b0;
    chk({nm, "_count"}, 32'(mon_q.size()), 32'($countones(ce)));
    for (int i = 0; i < 4; i++) begin
      if (ce[i]) begin
        if (k < mon_q.size()) begin
          chk($sformatf("%s_chn%0d", nm, i), 32'(mon_q[k].chn), 32'(i));
          chk($sformatf("%s_data%0d", nm, i), 32'(mon_q[k].data), 32'(ex[i]));
        end
        k++;
      end
    end
  endtask

  vec_t tbl[7];
  logic [15:0] bnd[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]       ce;
    logic [3:0][15:0] res, ex;
    int k;

    rstn = 1'b0; en = 1'b0; clr_err = 1'b0; chn_en = 4'h0;
    setpoint = '0; feedback = '0; pid_ack = 1'b0; pid_done = 1'b0; pid_result = '0;
    res_tbl = '0;
    repeat (3) @(negedge clk);
    chk("rst_pid_req", 32'(pid_req), 32'd0);
    chk("rst_pid_chn", 32'(pid_chn), 32'd0);
    chk("rst_pid_sp", 32'(pid_sp), 32'd0);
    chk("rst_u_valid", 32'(u_valid_o), 32'd0);
    chk("rst_u_chn", 32'(u_chn_o), 32'd0);
    chk("rst_u_data", 32'(u_data_o), 32'd0);
    chk("rst_stop", 32'(stop), 32'hF);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    tbl[0] = '{4'hF, {16'd1499, 16'd0, -16'sd200, 16'd100}, {16'd1499, 16'd0, -16'sd200, 16'd100}};
    tbl[1] = '{4'hF, {16'd1500, 16'h8000, -16'sd1501, 16'd2000}, {16'd1500, -16'sd1500, -16'sd1500, 16'd1500}};
    tbl[2] = '{4'b1010, {16'd8, 16'd7, 16'd6, 16'd5}, {16'd8, 16'd7, 16'd6, 16'd5}};
    tbl[3] = '{4'b0001, {16'd0, 16'd0, 16'd0, -16'sd1500}, {16'd0, 16'd0, 16'd0, -16'sd1500}};
    tbl[4] = '{4'b1001, {16'd1501, 16'd0, 16'd0, 16'h7FFF}, {16'd1500, 16'd0, 16'd0, 16'd1500}};
    tbl[5] = '{4'b0000, {16'd1, 16'd2, 16'd3, 16'd4}, {16'd0, 16'd0, 16'd0, 16'd0}};
    tbl[6] = '{4'b0110, {16'd0, -16'sd1000, -16'sd1499, 16'd0}, {16'd0, -16'sd1000, -16'sd1499, 16'd0}};
    done_lat = 3;
    for (int i = 0; i < 7; i++) run_vec($sformatf("vec%0d", i), tbl[i].ce, tbl[i].res, tbl[i].ex);

    bnd = '{16'd1500, 16'd1501, -16'sd1500, -16'sd1501, 16'h8000, 16'h7FFF};
    for (int r = 0; r < 16; r++) begin
      ce = 4'($urandom);
      for (int i = 0; i < 4; i++) begin
        case ($urandom_range(0, 2))
          0:       res[i] = 16'($urandom);
          1:       res[i] = 16'(int'($urandom_range(0, 3200)) - 1600);
          default: res[i] = bnd[$urandom_range(0, 5)];
        endcase
        ex[i] = sat_ref(res[i]);
      end
      done_lat = int'($urandom_range(1, 10));
      run_vec($sformatf("rnd%0d", r), ce, res, ex);
    end

    // control period: two consecutive sequences 100 cycles apart
    done_lat = 3;
    chn_en = 4'hF;
    res_tbl = tbl[0].res;
    start_seq();
    repeat (240) @(negedge clk);
    en = 1'b0;
    chk("period_count", 32'(mon_q.size()), 32'd8);
    if (mon_q.size() >= 5) begin
      chk("period_chn", 32'(mon_q[4].chn), 32'd0);
      chk("period_gap", 32'(mon_q[4].cyc - mon_q[0].cyc), 32'd100);
    end

    // snapshot: clearing chn_en[3] while chn 1 waits still services chn 3
    done_lat = 20;
    chn_en = 4'b1010;
    res_tbl = {16'd8, 16'd7, 16'd6, 16'd5};
    k = ack_cnt;
    start_seq();
    wait_ack(k + 1, 200, "snap_ack1_seen");
    chk("snap_ack1_chn", 32'(last_ack_chn), 32'd1);
    @(negedge clk);
    chk("snap_stop_before", 32'(stop), 32'b0101);
    chn_en = 4'b0010;
    @(negedge clk);
    chk("snap_stop_after", 32'(stop), 32'b1101);
    wait_ev(2, 100, "snap_events");
    if (mon_q.size() >= 2) begin
      chk("snap_chn_b", 32'(mon_q[1].chn), 32'd3);
      chk("snap_data_b", 32'(mon_q[1].data), 32'd8);
    end
    en = 1'b0;

    // timeout on channel 2
    done_lat = 3;
    never_done = 4'b0100;
    chn_en = 4'hF;
    res_tbl = tbl[0].res;
    start_seq();
    wait_ev(4, 700, "to_events");
    if (mon_q.size() >= 4) begin
      chk("to_chn2", 32'(mon_q[2].chn), 32'd2);
      chk("to_data2", 32'(mon_q[2].data), 32'd0);
      chk("to_gap", 32'(mon_q[2].cyc - mon_q[1].cyc), 32'd258);
      chk("to_chn3", 32'(mon_q[3].chn), 32'd3);
      chk("to_data3", 32'(mon_q[3].data), 32'd1499);
    end
    @(negedge clk);
    chk("to_flag", 32'(timeout_err), 32'b0100);
    chk("to_stop", 32'(stop), 32'b0100);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("to_flag_clr", 32'(timeout_err), 32'd0);
    chk("to_overrun_clr", 32'(overrun), 32'd0);
    @(negedge clk);
    chk("to_stop_rel", 32'(stop), 32'd0);
    never_done = 4'b0000;
    en = 1'b0;

    // overrun: ack held off past the second tick
    ack_allow = 1'b0;
    chn_en = 4'hF;
    res_tbl = tbl[1].res;
    start_seq();
    repeat (105) @(negedge clk);
    chk("ovr_req_held", 32'(pid_req), 32'd1);
    chk("ovr_before", 32'(overrun), 32'd0);
    repeat (145) @(negedge clk);
    chk("ovr_set", 32'(overrun), 32'd1);
    ack_allow = 1'b1;
    wait_ev(4, 100, "ovr_events");
    for (int i = 0; i < 4; i++) begin
      if (i < mon_q.size()) begin
        chk($sformatf("ovr_chn%0d", i), 32'(mon_q[i].chn), 32'(i));
        chk($sformatf("ovr_data%0d", i), 32'(mon_q[i].data), 32'(tbl[1].ex[i]));
      end
    end
    repeat (10) @(negedge clk);
    chk("ovr_no_extra", 32'(mon_q.size()), 32'd4);
    en = 1'b0;

    // abort while waiting: no emission, late done ignored
    done_lat = 20;
    k = ack_cnt;
    start_seq();
    wait_ack(k + 1, 200, "abort_ack_seen");
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("abort_req", 32'(pid_req), 32'd0);
    chk("abort_stop", 32'(stop), 32'hF);
    repeat (40) @(negedge clk);
    chk("abort_no_valid", 32'(mon_q.size()), 32'd0);

    // abort while requesting: pid_req drops
    ack_allow = 1'b0;
    start_seq();
    k = 0;
    while (!pid_req && k < 150) begin
      @(negedge clk);
      k++;
    end
    chk("abort_req_seen", 32'(pid_req), 32'd1);
    en = 1'b0;
    @(negedge clk);
    chk("abort_req_drop", 32'(pid_req), 32'd0);
    ack_allow = 1'b1;
    repeat (3) @(negedge clk);

    // asynchronous reset mid-sequence
    done_lat = 3;
    res_tbl = tbl[0].res;
    start_seq();
    wait_ev(1, 200, "arst_first_event");
    repeat (2) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("arst_u_valid", 32'(u_valid_o), 32'd0);
    chk("arst_u_data", 32'(u_data_o), 32'd0);
    chk("arst_u_chn", 32'(u_chn_o), 32'd0);
    chk("arst_pid_req", 32'(pid_req), 32'd0);
    chk("arst_pid_chn", 32'(pid_chn), 32'd0);
    chk("arst_stop", 32'(stop), 32'hF);
    chk("arst_overrun", 32'(overrun), 32'd0);
    chk("arst_timeout_err", 32'(timeout_err), 32'd0);
    en = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pid_channel_scheduler.md
Name: pid_channel_scheduler

Overview:
Time-multiplexes one shared PID compute core across the motor channels at a fixed control rate. On each control tick it walks the enabled channels in ascending order. For each channel it issues a request to the PID core, waits for the result, saturates it, and emits it on the u_valid_o/u_chn_o/u_data_o stream that feeds the PWM output stage. It also drives the per-channel stop vector and sticky error flags.

Parameters:
DATA_WIDTH, 16, width of setpoint, feedback and PID result (signed two's complement)
NUM_CHN, 4, number of motor channels (max 4)
CLK_FREQ, 27_000_000, clk frequency in Hz
CTRL_FREQ, 1000, control-loop rate in Hz; TICK_DIV = CLK_FREQ/CTRL_FREQ (default 27000)
RPM_MAX, 1500, saturation magnitude applied to PID results
TIMEOUT, 255, maximum cycles in WAIT before a channel is declared failed

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
en  in  1  global enable; 0 clears tick counter, aborts the sequence, stops all motors
chn_en  in  NUM_CHN  per-channel enable
clr_err  in  1  one-cycle pulse; clears overrun and timeout_err
setpoint  in  NUM_CHN*DATA_WIDTH  packed signed setpoints, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
feedback  in  NUM_CHN*DATA_WIDTH  packed signed measured speeds, same packing as setpoint
pid_req  out  1  request to PID core
pid_chn  out  3  channel index for the request
pid_sp  out  DATA_WIDTH  setpoint for the request
pid_fb  out  DATA_WIDTH  feedback for the request
pid_ack  in  1  core accepted the request
pid_done  in  1  one-cycle pulse; pid_result valid
pid_result  in  DATA_WIDTH  signed PID output
u_valid_o  out  1  one-cycle result strobe
u_chn_o  out  3  channel of the result
u_data_o  out  DATA_WIDTH  saturated signed result
stop  out  4  per-channel stop; bits at index >= NUM_CHN are tied to 1
overrun  out  1  sticky: a tick arrived while the sequence was busy
timeout_err  out  NUM_CHN  sticky per-channel PID timeout

Behaviour:
- Reset values: all outputs 0, except stop = 4'hF. FSM is in IDLE; tick counter, idx and wait counter are 0.
- Tick counter: increments while en=1, wraps at TICK_DIV-1. tick is asserted for the one cycle where the counter equals TICK_DIV-1. en=0 holds the counter at 0.
- FSM states: IDLE, SCAN, REQ, WAIT, EMIT.
- IDLE:
  - On tick: snapshot chn_en into snap, set idx=0, go to SCAN.
  - pid_done is ignored in IDLE.
- SCAN:
  - idx==NUM_CHN -> IDLE.
  - snap[idx]=1 -> REQ.
  - Otherwise idx+1, staying in SCAN (one cycle per skipped channel).
- REQ:
  - pid_req=1, pid_chn=idx, pid_sp/pid_fb driven from channel idx. All request outputs are registered and held stable until pid_ack=1 is sampled.
  - On ack: clear the wait counter, go to WAIT; pid_req is 0 from the next cycle.
  - pid_done sampled in REQ is ignored.
  - REQ itself has no timeout.
- WAIT:
  - Wait counter increments each cycle.
  - pid_done=1: capture sat(pid_result), go to EMIT. pid_done wins if it coincides with timeout.
  - Counter reaches TIMEOUT without done: set timeout_err[idx], capture 0, go to EMIT.
- EMIT:
  - u_valid_o=1 for exactly one cycle, with u_chn_o=idx and u_data_o set to the captured value.
  - Then idx+1, go to SCAN.
  - u_chn_o/u_data_o hold their last value when u_valid_o=0.
- Saturation:
  - Result is compared as signed.
  - Greater than +RPM_MAX -> +RPM_MAX; less than -RPM_MAX -> -RPM_MAX; otherwise passed unchanged.
  - -2^(DATA_WIDTH-1) saturates to -RPM_MAX.
- Overrun: a tick while the FSM is not in IDLE sets overrun. That tick is dropped and the current sequence continues.
- Sticky flags:
  - clr_err clears overrun and timeout_err.
  - A set event in the same cycle as clr_err wins.
- stop[i] (registered, 1-cycle latency): stop[i] = !en | !chn_en[i] | timeout_err[i].
- en falling mid-sequence: FSM goes to IDLE on the next edge; pid_req drops, no u_valid_o is emitted, and a late pid_done is ignored.
- chn_en changes mid-sequence do not affect the current sequence (snapshot), but stop follows them after 1 cycle.

Test Plan:
- Nominal: CLK_FREQ=1000, CTRL_FREQ=10 (TICK_DIV=100); all channels enabled; core acks immediately and returns done 3 cycles later with results 100, -200, 0, 1499 -> four u_valid_o pulses, chn 0..3 in order, with exactly those values; next sequence starts 100 cycles after the first.
- Saturation: pid_result = 2000, -1501, 16'h8000 -> u_data_o = 1500, -1500, -1500.
- Skip/snapshot: chn_en=4'b1010 -> requests only for chn 1 and 3; clearing chn_en[3] while chn 1 is in WAIT still services chn 3; stop=4'b0101 then 4'b1101 after 1 cycle.
- Timeout: core never returns done for chn 2 -> after 255 WAIT cycles timeout_err=4'b0100, u_data_o=0 for chn 2, stop[2]=1, chn 3 still serviced; clr_err clears the flag and releases stop[2].
- Overrun: pid_ack held low for 150 cycles -> overrun=1 at the second tick, that tick produces no extra sequence, and the first sequence completes normally.
- Abort/reset: drop en while in WAIT -> IDLE next cycle, pid_req=0, no u_valid_o, stop=4'hF; assert rstn=0 mid-sequence -> all outputs reach their reset values asynchronously.
